rvfi_commit_checker: RTL and testbench
======================================

# rvfi_commit_checker

Parametrised, synthesizable RVFI commit-stream checker for the N-wide retire port of the out-of-order core. It sits beside the simulation monitor on the same retirement signals. It checks order continuity, PC continuity, lane packing, halt behaviour and forward progress. It also keeps segment-aware instruction and cycle counters, so IPC can be read in simulation, emulation or FPGA without `$`-system tasks.

## Interface
Parameters:
- CHANNELS, 8, retire lanes per cycle (1..16)
- XLEN, 32, PC width
- ORDER_W, 64, width of RVFI order
- CNT_W, 64, width of performance counters
- TIMEOUT, 100000, cycles without a commit before a progress error (≥2)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- valid  in  CHANNELS  per-lane commit valid
- order  in  CHANNELS*ORDER_W  per-lane order, lane i at [i*ORDER_W +: ORDER_W]
- inst  in  CHANNELS*32  per-lane instruction word
- pc_rdata  in  CHANNELS*XLEN  per-lane PC of instruction
- pc_wdata  in  CHANNELS*XLEN  per-lane next PC
- halt  out  1  sticky halt-detected flag
- errcode  out  4  sticky error bits: [0] order, [1] pc, [2] protocol, [3] timeout
- error  out  1  OR of errcode
- inst_count  out  CNT_W  accepted commits in current segment
- cycle_count  out  CNT_W  cycles in current segment
- seg_active  out  1  start marker seen, stop not yet seen
- seg_done  out  1  stop marker seen; counters frozen

## Operation
- Accepted lanes: valid lanes in ascending index, up to and including the first halting lane. Lanes above a halting lane are ignored: not checked, not counted. While halt=1, nothing is accepted.
- Lane packing: valid must be of the form 0…01…1. Any other pattern sets errcode[2]. Checks still run on the valid lanes, in index order.
- Order check: exp_order resets to 0. The j-th accepted lane this cycle (j from 0) must carry order == exp_order + j; a mismatch sets errcode[0]. Then exp_order += number of accepted lanes. Addition wraps modulo 2^ORDER_W.
- PC check: pc_seeded resets to 0. Accepted lane j>0 must have pc_rdata == pc_wdata of accepted lane j−1. Lane j=0 must have pc_rdata == exp_pc when pc_seeded=1; the first commit after reset is not checked. A mismatch sets errcode[1]. exp_pc takes pc_wdata of the last accepted lane, and pc_seeded is set.
- Halt condition: pc_rdata == pc_wdata, or inst ∈ {0x00000063, 0x0000006F, 0xF0002013}. The halting lane is accepted and counted.
- Post-halt commits: any valid bit while halt=1 sets errcode[2].
- Timeout: idle counter resets to 0 and is cleared on any cycle with valid≠0. When it reaches TIMEOUT, errcode[3] is set. The counter saturates and is disabled while halt=1.
- Segment markers, processed per accepted lane in lane order:
  - start 0x00102013: inst_count is cleared, then counts only accepted lanes above the marker; cycle_count is cleared; seg_active=1; seg_done=0.
  - stop 0x00202013: the stop lane and lanes below it are counted; lanes above it are not; seg_active=0; seg_done=1.
  - Start and stop in the same cycle take effect in lane order.
- Counters:
  - With no markers, counting runs from reset.
  - cycle_count +1 each cycle while halt=0 and seg_done=0. On a start cycle it is set to 0.
  - inst_count adds accepted lanes while seg_done=0. Both counters wrap at 2^CNT_W.
- errcode bits never clear except on rst.

## Timing
- All outputs registered. Effects of the inputs at edge N are visible after edge N (next cycle).
- Reset values: halt=0, errcode=0, error=0, inst_count=0, cycle_count=0, seg_active=0, seg_done=0. Internal state also resets: exp_order=0, pc_seeded=0, idle counter 0.
- Reset asserted mid-run clears all state asynchronously. The first commit after deassert is the new seed; the order check expects 0.
- error is derived from registered errcode and has no extra cycle of latency.
- Simultaneous errors in one cycle set every applicable bit.

## Test plan
- Contiguous stream: 4 cycles of valid=0x0F, orders 0..15, pc 0x1000+4k, pc_wdata=pc+4 → errcode=0, inst_count=16, cycle_count=4.
- Order gap: cycle 0 orders 0..3 (valid=0x0F); cycle 1 lane 1 order=6, expected 5 → errcode=4'b0001 and error=1 one cycle later; stays set.
- PC break: lane 0 pc_wdata=0x1004, lane 1 pc_rdata=0x1008 → errcode[1]=1. Also valid=0x05 → errcode[2]=1.
- Halt: valid=0x3F, lane 2 inst=0x0000006F → halt=1 next cycle; inst_count +3. A later valid=0x01 → errcode[2]=1; cycle_count frozen.
- Timeout with TIMEOUT=16: one commit, then 16 idle cycles → errcode[3]=1 after the 16th idle edge, not before. The same idle run with halt=1 → no error.
- Segment: valid=0xFF with start marker in lane 3 → inst_count=4, cycle_count=0. Then 2 cycles of 0xFF and stop marker in lane 0 → inst_count=21, seg_done=1, counters frozen. rst pulse mid-segment → all outputs 0.

Source files
------------

// File: rtl/rvfi_commit_checker.sv
// RVFI N-wide retire-stream checker: order/PC continuity, lane packing, halt, progress, segment IPC counters.
// Latency: one cycle, every output registered. Backpressure: none, purely observes the retire port.
module rvfi_commit_checker #(
  parameter int CHANNELS = 8,
  parameter int XLEN     = 32,
  parameter int ORDER_W  = 64,
  parameter int CNT_W    = 64,
  parameter int TIMEOUT  = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      valid,
  input  logic [CHANNELS*ORDER_W-1:0] order,
  input  logic [CHANNELS*32-1:0]   inst,
  input  logic [CHANNELS*XLEN-1:0] pc_rdata,
  input  logic [CHANNELS*XLEN-1:0] pc_wdata,
  output logic                     halt,
  output logic [3:0]               errcode,
  output logic                     error,
  output logic [CNT_W-1:0]         inst_count,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     seg_active,
  output logic                     seg_done
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]   IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [CHANNELS-1:0] LANE_ONE  = CHANNELS'(1);
  localparam logic [31:0] SEG_START = 32'h0010_2013;
  localparam logic [31:0] SEG_STOP  = 32'h0020_2013;

  logic [ORDER_W-1:0] exp_order, nx_order;
  logic [XLEN-1:0]    exp_pc, nx_pc;
  logic               pc_seeded, nx_seeded;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               nx_halt, order_err, pc_err, pack_err, to_err, start_hit;
  logic               nx_active, nx_done;
  logic [CNT_W-1:0]   nx_inst;

  function automatic logic lane_halts(input logic [31:0] w, input logic [XLEN-1:0] r,
                                      input logic [XLEN-1:0] n);
    return (r == n) || (w == 32'h0000_0063) || (w == 32'h0000_006F) || (w == 32'hF000_2013);
  endfunction

  assign error = |errcode;

  // Walk the lanes in index order; running expectations advance per accepted lane so
  // lane j>0 is checked against lane j-1 and lane 0 against the previous cycle.
  always_comb begin
    logic        stop_scan;
    logic [31:0] w;
    logic [XLEN-1:0] r, n;
    nx_order  = exp_order;
    nx_pc     = exp_pc;
    nx_seeded = pc_seeded;
    nx_halt   = 1'b0;
    order_err = 1'b0;
    pc_err    = 1'b0;
    start_hit = 1'b0;
    nx_active = seg_active;
    nx_done   = seg_done;
    nx_inst   = inst_count;
    stop_scan = 1'b0;
    w         = '0;
    r         = '0;
    n         = '0;
    pack_err  = |(valid & (valid + LANE_ONE));
    if (!halt) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (valid[i] && !stop_scan) begin
          w = inst[i*32 +: 32];
          r = pc_rdata[i*XLEN +: XLEN];
          n = pc_wdata[i*XLEN +: XLEN];
          if (order[i*ORDER_W +: ORDER_W] != nx_order) order_err = 1'b1;
          if (nx_seeded && (r != nx_pc)) pc_err = 1'b1;
          nx_order  = nx_order + ORDER_W'(1);
          nx_pc     = n;
          nx_seeded = 1'b1;
          if (w == SEG_START) begin
            nx_inst   = '0;
            nx_done   = 1'b0;
            nx_active = 1'b1;
            start_hit = 1'b1;
          end else begin
            if (!nx_done) nx_inst = nx_inst + CNT_W'(1);
            if (w == SEG_STOP) begin
              nx_done   = 1'b1;
              nx_active = 1'b0;
            end
          end
          if (lane_halts(w, r, n)) begin
            nx_halt   = 1'b1;
            stop_scan = 1'b1;
          end
        end
      end
    end
    to_err = !halt && (valid == '0) && (idle_cnt >= IDLE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_order   <= '0;
      exp_pc      <= '0;
      pc_seeded   <= 1'b0;
      idle_cnt    <= '0;
      halt        <= 1'b0;
      errcode     <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
      seg_active  <= 1'b0;
      seg_done    <= 1'b0;
    end else begin
      exp_order  <= nx_order;
      exp_pc     <= nx_pc;
      pc_seeded  <= nx_seeded;
      inst_count <= nx_inst;
      seg_active <= nx_active;
      seg_done   <= nx_done;
      if (nx_halt) halt <= 1'b1;
      errcode <= errcode | {to_err, pack_err | (halt && (valid != '0)), pc_err, order_err};
      if (start_hit) cycle_count <= '0;
      else if (!halt && !seg_done) cycle_count <= cycle_count + CNT_W'(1);
      // Idle counter freezes once halted and saturates at TIMEOUT.
      if (!halt) begin
        if (valid != '0) idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rvfi_commit_checker.sv
// Randomised and directed retire streams against a queue-based reference model of the commit rules.
module tb_rvfi_commit_checker;
  localparam int CH = 8, XL = 32, OW = 8, CW = 16, TO = 16;
  localparam logic [31:0] M_START = 32'h0010_2013;
  localparam logic [31:0] M_STOP  = 32'h0020_2013;
  localparam logic [31:0] M_NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0]    valid = '0;
  logic [CH*OW-1:0] order = '0;
  logic [CH*32-1:0] inst = '0;
  logic [CH*XL-1:0] pc_rdata = '0, pc_wdata = '0;
  logic             halt, error, seg_active, seg_done;
  logic [3:0]       errcode;
  logic [CW-1:0]    inst_count, cycle_count;

  always #5 clk = ~clk;

  rvfi_commit_checker #(.CHANNELS(CH), .XLEN(XL), .ORDER_W(OW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid(valid), .order(order), .inst(inst),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .halt(halt), .errcode(errcode), .error(error),
    .inst_count(inst_count), .cycle_count(cycle_count), .seg_active(seg_active), .seg_done(seg_done)
  );

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_halt, m_seeded, m_active, m_done;
  bit [3:0]    m_err;
  int unsigned m_order, m_pc, m_inst, m_cyc;
  int          m_idle;
  int unsigned g_order, g_pc;

  function automatic int unsigned ord(int i); return int'(order[i*OW +: OW]); endfunction
  function automatic int unsigned ins(int i); return inst[i*32 +: 32]; endfunction
  function automatic int unsigned rd(int i);  return pc_rdata[i*XL +: XL]; endfunction
  function automatic int unsigned wr(int i);  return pc_wdata[i*XL +: XL]; endfunction
  function automatic bit halts(int i);
    return rd(i) == wr(i) || ins(i) == 32'h63 || ins(i) == 32'h6F || ins(i) == 32'hF0002013;
  endfunction

  task automatic model_reset();
    m_halt = 0; m_seeded = 0; m_active = 0; m_done = 0; m_err = 0;
    m_order = 0; m_pc = 0; m_inst = 0; m_cyc = 0; m_idle = 0;
    g_order = 0; g_pc = 32'h1000;
  endtask

  task automatic model_step();
    int q[$];
    int nv;
    bit start_hit = 0;
    bit old_halt = m_halt, old_done = m_done;
    bit [3:0] e = m_err;
    nv = $countones(valid);
    if (m_halt) begin
      if (valid != 0) e[2] = 1;
    end else begin
      if (int'(valid) != (1 << nv) - 1) e[2] = 1;
      for (int i = 0; i < CH; i++)
        if (valid[i]) begin
          q.push_back(i);
          if (halts(i)) break;
        end
      foreach (q[j]) begin
        if (ord(q[j]) != (m_order + j) % 256) e[0] = 1;
        if (j > 0) begin
          if (rd(q[j]) != wr(q[j-1])) e[1] = 1;
        end else if (m_seeded && rd(q[j]) != m_pc) e[1] = 1;
        if (ins(q[j]) == M_START) begin
          m_inst = 0; m_done = 0; m_active = 1; start_hit = 1;
        end else begin
          if (!m_done) m_inst = (m_inst + 1) % 65536;
          if (ins(q[j]) == M_STOP) begin m_done = 1; m_active = 0; end
        end
      end
      if (q.size() > 0) begin
        m_order = (m_order + q.size()) % 256;
        m_pc = wr(q[q.size()-1]);
        m_seeded = 1;
        if (halts(q[q.size()-1])) m_halt = 1;
      end
      if (valid != 0) m_idle = 0;
      else begin
        if (m_idle < TO) m_idle++;
        if (m_idle >= TO) e[3] = 1;
      end
    end
    if (start_hit) m_cyc = 0;
    else if (!old_halt && !old_done) m_cyc = (m_cyc + 1) % 65536;
    m_err = e;
  endtask

  task automatic check_outputs();
    chk("halt", halt, m_halt);
    chk("errcode", errcode, m_err);
    chk("error", error, |m_err);
    chk("inst_count", inst_count, m_inst);
    chk("cycle_count", cycle_count, m_cyc);
    chk("seg_active", seg_active, m_active);
    chk("seg_done", seg_done, m_done);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    valid = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    valid = '0;
    #2;
    model_reset();
    check_outputs();
    rst = 1'b0;
  endtask

  // Contiguous well-formed stream over the set lanes, continuing the generator.
  task automatic fill(input logic [CH-1:0] v);
    int r = 0;
    valid = v;
    for (int i = 0; i < CH; i++) begin
      order[i*OW +: OW]    = OW'(g_order + r);
      pc_rdata[i*XL +: XL] = XL'(g_pc + 4 * r);
      pc_wdata[i*XL +: XL] = XL'(g_pc + 4 * r + 4);
      inst[i*32 +: 32]     = M_NOP;
      if (v[i]) r++;
    end
    g_order += r;
    g_pc += 4 * r;
  endtask

  task automatic rand_cycle();
    logic [CH-1:0] v;
    logic [31:0] hw;
    int k;
    k = $urandom_range(0, 99);
    if (k < 20) v = '0;
    else if (k < 28) v = CH'($urandom);
    else v = CH'((1 << $urandom_range(1, CH)) - 1);
    fill(v);
    for (int i = 0; i < CH; i++) begin
      k = $urandom_range(0, 199);
      case ($urandom_range(0, 2))
        0: hw = 32'h63;
        1: hw = 32'h6F;
        default: hw = 32'hF0002013;
      endcase
      if (k < 6) inst[i*32 +: 32] = M_START;
      else if (k < 12) inst[i*32 +: 32] = M_STOP;
      else if (k < 14) inst[i*32 +: 32] = hw;
      else if (k < 16) pc_wdata[i*XL +: XL] = pc_rdata[i*XL +: XL];
      if ($urandom_range(0, 79) == 0) order[i*OW +: OW] ^= OW'(1);
      if ($urandom_range(0, 79) == 0) pc_rdata[i*XL +: XL] ^= XL'(4);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Contiguous stream
    do_reset();
    repeat (4) begin fill(8'h0F); tick(); end
    chk("contig_err", errcode, 0);
    chk("contig_inst", inst_count, 16);
    chk("contig_cyc", cycle_count, 4);

    // Order gap
    do_reset();
    fill(8'h0F); tick();
    fill(8'h0F); order[1*OW +: OW] = 8'd6; tick();
    chk("gap_err", errcode, 4'b0001);
    chk("gap_error", error, 1);
    fill(8'h0F); tick();
    chk("gap_sticky", errcode, 4'b0001);

    // PC break, then unpacked valid
    do_reset();
    fill(8'h0F); pc_rdata[1*XL +: XL] = 32'h1008; tick();
    chk("pc_err", errcode, 4'b0010);
    fill(8'h05); tick();
    chk("pack_err", errcode, 4'b0110);

    // Halt on lane 2
    do_reset();
    fill(8'h3F); inst[2*32 +: 32] = 32'h6F; tick();
    chk("halt_flag", halt, 1);
    chk("halt_inst", inst_count, 3);
    fill(8'h01); tick();
    chk("post_halt_err", errcode[2], 1);
    chk("halt_cyc", cycle_count, 1);

    // Timeout boundary
    do_reset();
    fill(8'h01); tick();
    repeat (15) tick();
    chk("to_before", errcode[3], 0);
    tick();
    chk("to_at", errcode[3], 1);
    do_reset();
    fill(8'h01); inst[31:0] = 32'h63; tick();
    repeat (20) tick();
    chk("to_halted", errcode[3], 0);

    // Segment markers
    do_reset();
    fill(8'hFF); inst[3*32 +: 32] = M_START; tick();
    chk("seg_inst0", inst_count, 4);
    chk("seg_cyc0", cycle_count, 0);
    repeat (2) begin fill(8'hFF); tick(); end
    fill(8'h01); inst[31:0] = M_STOP; tick();
    chk("seg_inst_stop", inst_count, 21);
    chk("seg_done_stop", seg_done, 1);
    fill(8'h03); tick();
    chk("seg_frozen", inst_count, 21);
    fill(8'hFF); inst[31:0] = M_START; tick();
    chk("seg_restart", seg_active, 1);
    do_reset();
    chk("rst_seg_active", seg_active, 0);

    // Random episodes
    repeat (25) begin
      do_reset();
      repeat (50) rand_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
